ws2812_frame_ctrl: RTL and testbench



---
 rtl/ws2812_frame_ctrl_if.sv | 12 +
 rtl/ws2812_frame_ctrl.sv | 151 +++++++++++++++
 tb/tb_ws2812_frame_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_frame_ctrl_if.sv
// Pixel stream handshake between the frame controller and the WS2812 bit serializer.
//   pix_valid : pix_data holds a pixel ready for the serializer
//   pix_data  : scaled pixel {g, r, b}, shifted out MSB first by the serializer
//   pix_ready : serializer accepts pix_data this cycle
interface ws2812_frame_ctrl_if;
    logic        pix_valid;
    logic [23:0] pix_data;
    logic        pix_ready;

    modport master (output pix_valid, output pix_data, input pix_ready);
    modport slave  (input pix_valid, input pix_data, output pix_ready);
endinterface

// File: rtl/ws2812_frame_ctrl.sv
// Frame-level controller for a WS2812 LED chain.
// Holds a host-writable GRB pixel buffer, scales each pixel by a global brightness
// latched at frame start, streams pixels to the serializer over a valid/ready
// handshake and then times the latch (reset) gap.
//   clk, rst        : clock, synchronous active-high reset
//   wr_en/addr/data : pixel buffer write port (out-of-range addresses ignored)
//   bright          : global brightness, sampled when a frame starts
//   start           : request one frame refresh (ignored while busy)
//   pix             : pixel stream to the serializer (master side)
//   latch           : high for the whole latch gap
//   busy            : frame in progress
//   frame_done      : one-cycle pulse on the last latch cycle
module ws2812_frame_ctrl #(
    parameter int unsigned NUM_LEDS    = 8,
    parameter int unsigned AW          = 8,
    parameter int unsigned DELAY_RESET = 13500
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [23:0]                wr_data,
    input  logic [7:0]                 bright,
    input  logic                       start,
    ws2812_frame_ctrl_if.master        pix,
    output logic                       latch,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int unsigned IW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int unsigned CW = (DELAY_RESET > 1) ? $clog2(DELAY_RESET) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_LEDS - 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(DELAY_RESET - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SEND,
        S_LATCH
    } state_t;

    logic [23:0]   mem [NUM_LEDS];
    logic [23:0]   rd_data;

    state_t        state, state_nx;
    logic [IW-1:0] idx, idx_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [7:0]    bright_q, bright_nx;
    logic          pix_valid_q, pix_valid_nx;
    logic [23:0]   pix_data_q, pix_data_nx;
    logic          latch_nx, busy_nx, frame_done_nx;
    logic          xfer;

    assign pix.pix_valid = pix_valid_q;
    assign pix.pix_data  = pix_data_q;
    assign xfer          = pix_valid_q && pix.pix_ready;

    // One channel: (c * (b + 1)) >> 8, so b=255 is identity and b=0 is black.
    function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'(c) * (16'(b) + 16'd1);
        return prod[15:8];
    endfunction

    // Pixel buffer: read-before-write, so a same-cycle write returns old data.
    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_addr) < NUM_LEDS)) begin
            mem[IW'(wr_addr)] <= wr_data;
        end
        if (state == S_FETCH) begin
            rd_data <= mem[idx];
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            cnt         <= '0;
            bright_q    <= '0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            latch       <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_nx;
            idx         <= idx_nx;
            cnt         <= cnt_nx;
            bright_q    <= bright_nx;
            pix_valid_q <= pix_valid_nx;
            pix_data_q  <= pix_data_nx;
            latch       <= latch_nx;
            busy        <= busy_nx;
            frame_done  <= frame_done_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_FETCH;
            S_FETCH: state_nx = S_LOAD;
            S_LOAD:  state_nx = S_SEND;
            S_SEND:  if (xfer) state_nx = (idx == LAST_IDX) ? S_LATCH : S_FETCH;
            S_LATCH: if (cnt == LAST_CNT) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath and output next values; outputs decode the upcoming state so they are registered.
    always_comb begin
        idx_nx      = idx;
        cnt_nx      = cnt;
        bright_nx   = bright_q;
        pix_data_nx = pix_data_q;
        case (state)
            S_IDLE: begin
                if (start) begin
                    idx_nx    = '0;
                    bright_nx = bright;
                end
            end
            S_LOAD: begin
                pix_data_nx = {scale_ch(rd_data[23:16], bright_q),
                               scale_ch(rd_data[15:8],  bright_q),
                               scale_ch(rd_data[7:0],   bright_q)};
            end
            S_SEND: begin
                if (xfer) begin
                    if (idx == LAST_IDX) begin
                        cnt_nx = '0;
                    end else begin
                        idx_nx = idx + IW'(1);
                    end
                end
            end
            S_LATCH: cnt_nx = cnt + CW'(1);
            default: ;
        endcase
        pix_valid_nx  = (state_nx == S_SEND);
        latch_nx      = (state_nx == S_LATCH);
        busy_nx       = (state_nx != S_IDLE);
        frame_done_nx = (state_nx == S_LATCH) && (cnt_nx == LAST_CNT);
    end

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Self-checking bench for ws2812_frame_ctrl: scoreboard of expected scaled pixels,
// a negedge monitor for the stream and latch gap, and directed plus random frames.
module tb_ws2812_frame_ctrl;
    localparam int unsigned N  = 3;
    localparam int unsigned D  = 10;
    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [23:0]   wr_data = '0;
    logic [7:0]    bright = '0;
    logic          start = 1'b0;
    logic          latch, busy, frame_done;

    ws2812_frame_ctrl_if pix_if ();

    ws2812_frame_ctrl #(.NUM_LEDS(N), .AW(AW), .DELAY_RESET(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .bright     (bright),
        .start      (start),
        .pix        (pix_if),
        .latch      (latch),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [23:0] model_mem [4];
    logic [23:0] exp_q [$];
    int          xfer_count = 0;
    int          fd_count = 0;
    int          rdy_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference brightness rule, channel by channel in plain integer arithmetic.
    function automatic logic [23:0] ref_pixel(input logic [23:0] p, input logic [7:0] b);
        int m, g, r, bl;
        m  = int'(b) + 1;
        g  = int'(p[23:16]) * m / 256;
        r  = int'(p[15:8]) * m / 256;
        bl = int'(p[7:0]) * m / 256;
        return {8'(g), 8'(r), 8'(bl)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_px(input logic [AW-1:0] a, input logic [23:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en = 1'b0;
        if (int'(a) < int'(N)) model_mem[2'(a)] = d;
    endtask

    task automatic push_frame();
        for (int i = 0; i < int'(N); i++) exp_q.push_back(ref_pixel(model_mem[2'(i)], bright));
    endtask

    // One frame from an idle controller; reports busy cycles and the cycle pix_valid first rose.
    task automatic run_frame(input bit pulse_mid, input bit chg_bright,
                             output int busy_cyc, output int first_v);
        int k;
        push_frame();
        start = 1'b1;
        step();
        start    = 1'b0;
        k        = 1;
        busy_cyc = 0;
        first_v  = 0;
        if (chg_bright) bright = 8'($urandom);
        while (busy && k < 2000) begin
            busy_cyc++;
            if (pix_if.pix_valid && first_v == 0) first_v = k;
            start = pulse_mid && (pix_if.pix_valid || latch) && ($urandom_range(0, 2) == 0);
            step();
            k++;
        end
        start = 1'b0;
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout: busy still %0d after %0d cycles, required 0", busy, k);
        end
    endtask

    // Serializer model: always ready, random, or 20 cycles of backpressure per pixel.
    int hold_cnt = 0;
    bit prev_v = 1'b0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: pix_if.pix_ready = 1'b1;
            1: pix_if.pix_ready = 1'($urandom_range(0, 1));
            default: begin
                if (pix_if.pix_valid && !prev_v) hold_cnt = 20;
                pix_if.pix_ready = (hold_cnt == 0);
                if (hold_cnt > 0) hold_cnt--;
            end
        endcase
        prev_v = pix_if.pix_valid;
    end

    // Monitor: values seen here are those the next rising edge will act on.
    logic [23:0] held_data;
    bit          prev_hold = 1'b0, prev_xfer = 1'b0, prev_fd = 1'b0;
    int          latch_run = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
            prev_xfer = 1'b0;
            prev_fd   = 1'b0;
            latch_run = 0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 32'(pix_if.pix_valid), 32'd1);
                chk("hold_data", 32'(pix_if.pix_data), 32'(held_data));
            end
            if (prev_xfer) chk("valid_drop_after_xfer", 32'(pix_if.pix_valid), 32'd0);
            if (prev_fd) begin
                chk("frame_done_single", 32'(frame_done), 32'd0);
                chk("latch_after_done", 32'(latch), 32'd0);
            end
            if (frame_done) begin
                fd_count++;
                chk("done_with_latch", 32'(latch), 32'd1);
            end
            if (latch) begin
                latch_run++;
            end else if (latch_run != 0) begin
                chk("latch_len", 32'(latch_run), 32'(D));
                latch_run = 0;
            end
            prev_hold = pix_if.pix_valid && !pix_if.pix_ready;
            held_data = pix_if.pix_data;
            prev_xfer = pix_if.pix_valid && pix_if.pix_ready;
            prev_fd   = frame_done;
            if (prev_xfer) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pixel: got %06h, required no transfer", pix_if.pix_data);
                end else begin
                    chk("pixel", 32'(pix_if.pix_data), 32'(exp_q.pop_front()));
                end
                xfer_count++;
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(pix_if.pix_valid), 32'd0);
        chk({tag, "_data"}, 32'(pix_if.pix_data), 32'd0);
        chk({tag, "_latch"}, 32'(latch), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(frame_done), 32'd0);
    endtask

    task automatic chk_frame_end(input string tag, input int base_x, input int base_fd, input int frames);
        chk({tag, "_xfers"}, 32'(xfer_count - base_x), 32'(frames * int'(N)));
        chk({tag, "_done_count"}, 32'(fd_count - base_fd), 32'(frames));
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int bc, fv, base_x, base_fd, k, gap;

        repeat (3) step();
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Basic frame, identity brightness, always-ready serializer.
        rdy_mode = 0;
        write_px(8'd0, 24'hFF0000);
        write_px(8'd1, 24'h00FF00);
        write_px(8'd2, 24'h0000FF);
        bright  = 8'd255;
        base_x  = xfer_count;
        base_fd = fd_count;
        run_frame(1'b0, 1'b0, bc, fv);
        chk("frame_busy_cycles", 32'(bc), 32'(3 * N + D));
        chk("start_latency", 32'(fv), 32'd3);
        chk_frame_end("basic", base_x, base_fd, 1);
        repeat (3) step();
        chk("idle_after_frame", 32'(busy), 32'd0);

        // Brightness scaling, with a mid-frame change that must not affect this frame.
        write_px(8'd0, 24'hFF8040);
        bright  = 8'd127;
        base_x  = xfer_count;
        base_fd = fd_count;
        run_frame(1'b0, 1'b1, bc, fv);
        bright = 8'd0;
        run_frame(1'b0, 1'b0, bc, fv);
        chk_frame_end("bright", base_x, base_fd, 2);

        // Backpressure of 20 cycles per pixel, start pulses in S_SEND and S_LATCH.
        rdy_mode = 2;
        bright   = 8'd200;
        base_x   = xfer_count;
        base_fd  = fd_count;
        run_frame(1'b1, 1'b0, bc, fv);
        chk("bp_busy_cycles", 32'(bc), 32'(N * 23 + D));
        chk_frame_end("bp", base_x, base_fd, 1);
        repeat (3) step();
        chk("bp_no_extra_frame", 32'(busy), 32'd0);

        // Out-of-range writes, and a write to pixel 1 on the cycle it is fetched.
        rdy_mode = 0;
        bright   = 8'd255;
        write_px(8'd3, 24'h123456);
        write_px(8'd200, 24'hABCDEF);
        base_x  = xfer_count;
        base_fd = fd_count;
        push_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (xfer_count == base_x && k < 100) begin
            step();
            k++;
        end
        wr_en   = 1'b1;
        wr_addr = 8'd1;
        wr_data = 24'h5A5A5A;
        step();
        wr_en = 1'b0;
        model_mem[1] = 24'h5A5A5A;
        k = 0;
        while (busy && k < 200) begin
            step();
            k++;
        end
        chk("boundary_frame_ends", 32'(busy), 32'd0);
        chk_frame_end("boundary", base_x, base_fd, 1);
        base_x  = xfer_count;
        base_fd = fd_count;
        run_frame(1'b0, 1'b0, bc, fv);
        chk_frame_end("boundary_next", base_x, base_fd, 1);

        // Held start: two frames with exactly one idle cycle between them.
        base_x  = xfer_count;
        base_fd = fd_count;
        push_frame();
        push_frame();
        start = 1'b1;
        step();
        k = 0;
        while (busy && k < 200) begin
            step();
            k++;
        end
        gap = 0;
        while (!busy && k < 200) begin
            gap++;
            step();
            k++;
        end
        start = 1'b0;
        while (busy && k < 400) begin
            step();
            k++;
        end
        chk("held_gap", 32'(gap), 32'd1);
        chk("held_ends", 32'(busy), 32'd0);
        chk_frame_end("held", base_x, base_fd, 2);

        // Reset while pixel 1 is presented.
        base_x = xfer_count;
        push_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (!(xfer_count > base_x && pix_if.pix_valid) && k < 100) begin
            step();
            k++;
        end
        chk("rst_reached_pixel1", 32'(xfer_count - base_x), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        step();
        chk_reset_outputs("midrst");
        rst     = 1'b0;
        base_x  = xfer_count;
        base_fd = fd_count;
        run_frame(1'b0, 1'b0, bc, fv);
        chk_frame_end("after_rst", base_x, base_fd, 1);

        // Randomized frames: random writes, brightness, ready pattern and mid-frame pulses.
        rdy_mode = 1;
        for (int it = 0; it < 8; it++) begin
            for (int w = 0; w < int'($urandom_range(1, 4)); w++) begin
                write_px(8'($urandom_range(0, 5)), 24'($urandom));
            end
            bright  = 8'($urandom);
            base_x  = xfer_count;
            base_fd = fd_count;
            run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), bc, fv);
            chk_frame_end("random", base_x, base_fd, 1);
        end

        repeat (2) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
